// File: rtl/bcd_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_updown_counter
//  Purpose  : Multi-digit packed-BCD up/down counter with a runtime wrap
//             limit, validated synchronous load and registered carry/borrow
//             pulses for chaining into the next stage's enable.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_updown_counter #(
    parameter int                  DIGITS  = 2,
    parameter logic [4*DIGITS-1:0] RST_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic [4*DIGITS-1:0]   max_val,
    output logic [4*DIGITS-1:0]   cnt,
    output logic                  carry,
    output logic                  borrow,
    output logic                  load_err
);

    localparam int c_WIDTH = 4 * DIGITS;

    // w_all9_below[k] / w_all0_below[k]: every digit below k is 9 / 0,
    // i.e. digit k receives the ripple on increment / decrement.
    logic [DIGITS-1:0]  w_all9_below;
    logic [DIGITS-1:0]  w_all0_below;
    logic [c_WIDTH-1:0] w_inc;
    logic [c_WIDTH-1:0] w_dec;
    logic [DIGITS-1:0]  w_nib_ok;
    logic               w_load_ok;
    logic               w_at_zero;

    assign w_all9_below[0] = 1'b1;
    assign w_all0_below[0] = 1'b1;

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            logic [3:0] w_digit;
            assign w_digit = cnt[4*k +: 4];

            if (k < DIGITS - 1) begin : g_ripple
                assign w_all9_below[k+1] = w_all9_below[k] & (w_digit == 4'd9);
                assign w_all0_below[k+1] = w_all0_below[k] & (w_digit == 4'd0);
            end

            assign w_inc[4*k +: 4] = !w_all9_below[k]  ? w_digit :
                                     (w_digit == 4'd9) ? 4'd0    : w_digit + 4'd1;
            assign w_dec[4*k +: 4] = !w_all0_below[k]  ? w_digit :
                                     (w_digit == 4'd0) ? 4'd9    : w_digit - 4'd1;

            assign w_nib_ok[k] = (load_val[4*k +: 4] <= 4'd9);
        end
    endgenerate

    // Packed compare is a valid magnitude compare because both sides are BCD.
    assign w_load_ok = (&w_nib_ok) && (load_val <= max_val);
    assign w_at_zero = (cnt == '0);

    // Count register and one-cycle status pulses; priority rst > load > en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= RST_VAL;
            carry    <= 1'b0;
            borrow   <= 1'b0;
            load_err <= 1'b0;
        end else begin
            carry    <= 1'b0;
            borrow   <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                if (w_load_ok) begin
                    cnt <= load_val;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (en) begin
                if (up) begin
                    // >= also catches a limit lowered below the current count.
                    if (cnt >= max_val) begin
                        cnt   <= '0;
                        carry <= 1'b1;
                    end else begin
                        cnt <= w_inc;
                    end
                end else begin
                    if (w_at_zero) begin
                        cnt    <= max_val;
                        borrow <= 1'b1;
                    end else if (cnt > max_val) begin
                        // Limit lowered below count: clamp without a pulse.
                        cnt <= max_val;
                    end else begin
                        cnt <= w_dec;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_updown_counter
//  Purpose  : Self-checking bench for bcd_updown_counter (2-digit scoreboard,
//             chained hours/minutes pair, 4-digit ripple instance).
//  Revision : 1.0  initial release
// ============================================================================
module tb_bcd_updown_counter;

    typedef struct {
        logic [7:0] cnt;
        logic       carry;
        logic       borrow;
        logic       load_err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Main 2-digit instance
    logic       en, up, load;
    logic [7:0] load_val, max_val, cnt;
    logic       carry, borrow, load_err;

    // Chained minutes -> hours
    logic       mn_en, mn_up, mn_load, hr_load, hr_en;
    logic [7:0] mn_lv, hr_lv, mn_cnt, hr_cnt;
    logic       mn_carry, mn_borrow, mn_lerr, hr_carry, hr_borrow, hr_lerr;
    assign hr_en = mn_carry | mn_borrow;

    // 4-digit instance
    logic        d4_en, d4_up, d4_load;
    logic [15:0] d4_lv, d4_cnt;
    logic        d4_carry, d4_borrow, d4_lerr;

    int   n_checks = 0;
    int   n_errors = 0;
    int   m_val    = 0;
    exp_t sb_q[$];

    bcd_updown_counter #(.DIGITS(2), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .max_val(max_val), .cnt(cnt),
        .carry(carry), .borrow(borrow), .load_err(load_err)
    );

    bcd_updown_counter #(.DIGITS(2), .RST_VAL(8'h00)) u_min (
        .clk(clk), .rst(rst), .en(mn_en), .up(mn_up), .load(mn_load),
        .load_val(mn_lv), .max_val(8'h59), .cnt(mn_cnt),
        .carry(mn_carry), .borrow(mn_borrow), .load_err(mn_lerr)
    );

    bcd_updown_counter #(.DIGITS(2), .RST_VAL(8'h00)) u_hr (
        .clk(clk), .rst(rst), .en(hr_en), .up(mn_up), .load(hr_load),
        .load_val(hr_lv), .max_val(8'h23), .cnt(hr_cnt),
        .carry(hr_carry), .borrow(hr_borrow), .load_err(hr_lerr)
    );

    bcd_updown_counter #(.DIGITS(4), .RST_VAL(16'h0000)) u_d4 (
        .clk(clk), .rst(rst), .en(d4_en), .up(d4_up), .load(d4_load),
        .load_val(d4_lv), .max_val(16'h9999), .cnt(d4_cnt),
        .carry(d4_carry), .borrow(d4_borrow), .load_err(d4_lerr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int bcd2int(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        logic [3:0] t, o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    // Drive one cycle of stimulus on the main instance, predict via the
    // decimal model, then compare after the edge.
    task automatic step(input logic l_i, input logic [7:0] lv_i, input logic en_i,
                        input logic up_i, input logic [7:0] mx_i);
        exp_t e, g;
        int   mx;
        mx = bcd2int(mx_i);
        e.carry = 1'b0; e.borrow = 1'b0; e.load_err = 1'b0;
        if (l_i) begin
            if (lv_i[3:0] <= 4'd9 && lv_i[7:4] <= 4'd9 && bcd2int(lv_i) <= mx)
                m_val = bcd2int(lv_i);
            else
                e.load_err = 1'b1;
        end else if (en_i) begin
            if (up_i) begin
                if (m_val >= mx) begin m_val = 0; e.carry = 1'b1; end
                else m_val = m_val + 1;
            end else begin
                if (m_val == 0)      begin m_val = mx; e.borrow = 1'b1; end
                else if (m_val > mx) m_val = mx;
                else                 m_val = m_val - 1;
            end
        end
        e.cnt = int2bcd(m_val);
        sb_q.push_back(e);
        load = l_i; load_val = lv_i; en = en_i; up = up_i; max_val = mx_i;
        @(posedge clk);
        #1;
        g = sb_q.pop_front();
        check("cnt",      {24'd0, cnt},    {24'd0, g.cnt});
        check("carry",    {31'd0, carry},  {31'd0, g.carry});
        check("borrow",   {31'd0, borrow}, {31'd0, g.borrow});
        check("load_err", {31'd0, load_err}, {31'd0, g.load_err});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] mx_tab [6];
        mx_tab = '{8'h59, 8'h23, 8'h09, 8'h00, 8'h99, 8'h45};
        rst = 1'b0;
        en = 0; up = 0; load = 0; load_val = 0; max_val = 8'h59;
        mn_en = 0; mn_up = 1; mn_load = 0; hr_load = 0; mn_lv = 0; hr_lv = 0;
        d4_en = 0; d4_up = 1; d4_load = 0; d4_lv = 0;

        // Reset takes effect before any clock edge
        #1 rst = 1'b1;
        #1;
        check("rst_cnt",      {24'd0, cnt}, 32'h00);
        check("rst_carry",    {31'd0, carry}, 32'd0);
        check("rst_borrow",   {31'd0, borrow}, 32'd0);
        check("rst_load_err", {31'd0, load_err}, 32'd0);
        check("rst_d4_cnt",   {16'd0, d4_cnt}, 32'h0000);
        tick(); tick();
        rst = 1'b0;
        m_val = 0;

        // Up count 00..59 and wrap with carry
        for (int i = 0; i < 61; i++) step(1'b0, 8'h00, 1'b1, 1'b1, 8'h59);

        // Load 10 then count down through 00 to a borrow wrap
        step(1'b1, 8'h10, 1'b0, 1'b0, 8'h59);
        for (int i = 0; i < 14; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 8'h59);

        // Asynchronous reset mid-cycle
        #2 rst = 1'b1;
        #1;
        check("async_rst_cnt", {24'd0, cnt}, 32'h00);
        tick();
        check("rst_hold_cnt", {24'd0, cnt}, 32'h00);
        rst = 1'b0;
        m_val = 0;

        // Load validation
        step(1'b1, 8'h33, 1'b0, 1'b0, 8'h59);
        step(1'b1, 8'h5A, 1'b0, 1'b0, 8'h59);
        step(1'b1, 8'h60, 1'b0, 1'b0, 8'h59);
        step(1'b1, 8'h42, 1'b0, 1'b0, 8'h59);
        step(1'b1, 8'h17, 1'b1, 1'b1, 8'h59);
        step(1'b1, 8'hA5, 1'b1, 1'b0, 8'h59);

        // Limit lowered below count
        step(1'b1, 8'h45, 1'b0, 1'b0, 8'h59);
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h23);
        step(1'b1, 8'h45, 1'b0, 1'b0, 8'h59);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h23);

        // Hold
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 8'h59);

        // max_val = 0
        step(1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);

        // Random mix
        for (int i = 0; i < 300; i++) begin
            logic [7:0] lv;
            lv = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                             : int2bcd($urandom_range(0, 99));
            step(($urandom_range(0, 4) == 0), lv, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), mx_tab[$urandom_range(0, 5)]);
        end
        en = 0; load = 0;

        // Chained minutes -> hours, up
        mn_lv = 8'h59; hr_lv = 8'h23; mn_load = 1; hr_load = 1; mn_up = 1;
        tick();
        check("chain_preset_min", {24'd0, mn_cnt}, 32'h59);
        check("chain_preset_hr",  {24'd0, hr_cnt}, 32'h23);
        mn_load = 0; hr_load = 0; mn_en = 1;
        tick();
        check("chain_min_wrap",   {24'd0, mn_cnt}, 32'h00);
        check("chain_min_carry",  {31'd0, mn_carry}, 32'd1);
        check("chain_hr_hold",    {24'd0, hr_cnt}, 32'h23);
        check("chain_hr_carry0",  {31'd0, hr_carry}, 32'd0);
        tick();
        check("chain_min_next",   {24'd0, mn_cnt}, 32'h01);
        check("chain_min_carry1", {31'd0, mn_carry}, 32'd0);
        check("chain_hr_wrap",    {24'd0, hr_cnt}, 32'h00);
        check("chain_hr_carry",   {31'd0, hr_carry}, 32'd1);
        mn_en = 0;
        tick();
        check("chain_hr_stay",    {24'd0, hr_cnt}, 32'h00);
        check("chain_hr_carry_end", {31'd0, hr_carry}, 32'd0);

        // Chained, down
        mn_lv = 8'h00; hr_lv = 8'h00; mn_load = 1; hr_load = 1;
        tick();
        mn_load = 0; hr_load = 0; mn_up = 0; mn_en = 1;
        tick();
        check("chain_dn_min",     {24'd0, mn_cnt}, 32'h59);
        check("chain_dn_borrow",  {31'd0, mn_borrow}, 32'd1);
        check("chain_dn_hr_hold", {24'd0, hr_cnt}, 32'h00);
        mn_en = 0;
        tick();
        check("chain_dn_hr",      {24'd0, hr_cnt}, 32'h23);
        check("chain_dn_hr_borrow", {31'd0, hr_borrow}, 32'd1);

        // Four digits: ripple and full wrap
        d4_lv = 16'h0999; d4_load = 1;
        tick();
        d4_load = 0; d4_en = 1; d4_up = 1;
        tick();
        check("d4_ripple_up", {16'd0, d4_cnt}, 32'h1000);
        d4_up = 0;
        tick();
        check("d4_ripple_dn", {16'd0, d4_cnt}, 32'h0999);
        d4_en = 0; d4_lv = 16'h9998; d4_load = 1;
        tick();
        d4_load = 0; d4_en = 1; d4_up = 1;
        tick();
        check("d4_9999", {16'd0, d4_cnt}, 32'h9999);
        tick();
        check("d4_wrap",       {16'd0, d4_cnt}, 32'h0000);
        check("d4_wrap_carry", {31'd0, d4_carry}, 32'd1);
        d4_en = 0;
        tick();
        check("d4_carry_end",  {31'd0, d4_carry}, 32'd0);
        check("d4_hold",       {16'd0, d4_cnt}, 32'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
